serial_move_rx: RTL and testbench



---
 rtl/serial_pkg.sv | 21 ++
 rtl/baud_tick_gen.sv | 28 ++
 rtl/serial_move_rx.sv | 164 ++++++++++++++++
 tb/tb_serial_move_rx.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared types and constants for the inter-board serial move link (rx and tx sides).
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    HOLDOFF
  } rx_state_t;

  localparam logic [3:0] SAMP_LO   = 4'd7;
  localparam logic [3:0] SAMP_MID  = 4'd8;
  localparam logic [3:0] SAMP_HI   = 4'd9;
  localparam logic [3:0] LAST_SAMP = 4'd15;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Oversample tick generator: one-cycle tick every CLK_PER_SAMP clocks while run_in is high.
module baud_tick_gen #(
  parameter int CLK_PER_SAMP = 423
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic run_in,
  output logic tick_out
);

  localparam int CW = (CLK_PER_SAMP > 1) ? $clog2(CLK_PER_SAMP) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_SAMP - 1);

  logic [CW-1:0] clk_cnt_q, clk_cnt_d;

  always_comb begin
    clk_cnt_d = clk_cnt_q + 1'b1;
    if (!run_in || (clk_cnt_q == CNT_LAST)) clk_cnt_d = '0;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) clk_cnt_q <= '0;
    else         clk_cnt_q <= clk_cnt_d;
  end

  assign tick_out = run_in && (clk_cnt_q == CNT_LAST);

endmodule

// File: rtl/serial_move_rx.sv
// 8N1 receiver for the move link: 16x oversampling, 3-sample majority vote, framing check,
// and a post-frame hold-off that absorbs line turnaround between boards.
//
// state   | meaning
// IDLE    | waiting for a 1->0 edge on the synchronised line
// START   | validating the start bit at its centre
// DATA    | collecting PKT_LEN bits, LSB first
// STOP    | checking the stop bit, publishing the byte or flagging a framing error
// HOLDOFF | line ignored for WAITING_COUNT clocks
module serial_move_rx
  import serial_pkg::*;
#(
  parameter int CLK_HZ        = 65_000_000,
  parameter int BAUD_RATE     = 9600,
  parameter int SAMP_PER_BIT  = 16,
  parameter int PKT_LEN       = 8,
  parameter int CLK_PER_SAMP  = 423,
  parameter int WAITING_COUNT = 65_000
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rx_in,
  output logic [PKT_LEN-1:0] data_out,
  output logic               ready,
  output logic               frame_err,
  output logic               busy
);

  if (SAMP_PER_BIT != 16) begin : g_bad_samp
    $error("serial_move_rx: SAMP_PER_BIT must be 16");
  end
  if (CLK_PER_SAMP != CLK_HZ / BAUD_RATE / SAMP_PER_BIT) begin : g_bad_rate
    $error("serial_move_rx: CLK_PER_SAMP inconsistent with CLK_HZ/BAUD_RATE");
  end

  localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int HW = (WAITING_COUNT > 1) ? $clog2(WAITING_COUNT) : 1;
  localparam logic [BW-1:0] LAST_BIT  = BW'(PKT_LEN - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(WAITING_COUNT - 1);

  rx_state_t          state_q, state_d;
  logic               sync1_q, rx_s_q, rx_prev_q;
  logic [3:0]         samp_cnt_q, samp_cnt_d;
  logic [BW-1:0]      bit_idx_q, bit_idx_d;
  logic [PKT_LEN-1:0] shift_q, shift_d;
  logic [PKT_LEN-1:0] data_q, data_d;
  logic               s_lo_q, s_lo_d, s_mid_q, s_mid_d;
  logic               ready_q, ready_d, ferr_q, ferr_d;
  logic [HW-1:0]      hold_cnt_q, hold_cnt_d;
  logic               run, tick, vote, fall_edge;

  assign run = (state_q == START) || (state_q == DATA) || (state_q == STOP);

  baud_tick_gen #(.CLK_PER_SAMP(CLK_PER_SAMP)) u_tick (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .run_in   (run),
    .tick_out (tick)
  );

  // Third vote sample is the live synchronised line on the samp_cnt=9 tick.
  assign vote      = majority3(s_lo_q, s_mid_q, rx_s_q);
  assign fall_edge = rx_prev_q && !rx_s_q;

  always_comb begin
    state_d    = state_q;
    samp_cnt_d = samp_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    data_d     = data_q;
    s_lo_d     = s_lo_q;
    s_mid_d    = s_mid_q;
    ready_d    = 1'b0;
    ferr_d     = 1'b0;
    hold_cnt_d = hold_cnt_q;

    if (tick) begin
      samp_cnt_d = samp_cnt_q + 4'd1;
      if (samp_cnt_q == SAMP_LO)  s_lo_d  = rx_s_q;
      if (samp_cnt_q == SAMP_MID) s_mid_d = rx_s_q;
    end

    case (state_q)
      IDLE: begin
        samp_cnt_d = '0;
        bit_idx_d  = '0;
        if (fall_edge) state_d = START;
      end
      START: begin
        if (tick && (samp_cnt_q == SAMP_HI) && vote) begin
          state_d    = IDLE;
          samp_cnt_d = '0;
        end else if (tick && (samp_cnt_q == LAST_SAMP)) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (tick && (samp_cnt_q == SAMP_HI)) shift_d[bit_idx_q] = vote;
        if (tick && (samp_cnt_q == LAST_SAMP)) begin
          if (bit_idx_q == LAST_BIT) state_d = STOP;
          else                       bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      STOP: begin
        if (tick && (samp_cnt_q == SAMP_HI)) begin
          if (vote) begin
            data_d  = shift_q;
            ready_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
          state_d    = HOLDOFF;
          samp_cnt_d = '0;
          hold_cnt_d = HOLD_LOAD;
        end
      end
      HOLDOFF: begin
        samp_cnt_d = '0;
        if (hold_cnt_q == '0) state_d = IDLE;
        else                  hold_cnt_d = hold_cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sync1_q    <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_prev_q  <= 1'b1;
      state_q    <= IDLE;
      samp_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      s_lo_q     <= 1'b0;
      s_mid_q    <= 1'b0;
      ready_q    <= 1'b0;
      ferr_q     <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      sync1_q    <= rx_in;
      rx_s_q     <= sync1_q;
      rx_prev_q  <= rx_s_q;
      state_q    <= state_d;
      samp_cnt_q <= samp_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      s_lo_q     <= s_lo_d;
      s_mid_q    <= s_mid_d;
      ready_q    <= ready_d;
      ferr_q     <= ferr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign data_out  = data_q;
  assign ready     = ready_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_serial_move_rx.sv
// Directed bench for serial_move_rx, run at a scaled-down baud ratio (5 clocks per sample tick).
module tb_serial_move_rx;

  localparam int CPS  = 5;
  localparam int BIT  = 16 * CPS;
  localparam int WAIT = 768;
  localparam int LAT  = (1 + 8) * 16 * CPS + 10 * CPS + 3;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic       rx_in  = 1'b1;
  logic [7:0] data_out;
  logic       ready, frame_err, busy;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int ready_cnt = 0;
  int ferr_cnt = 0;
  int ready_cyc = -1;
  bit overlap = 1'b0;
  bit wide = 1'b0;
  logic ready_prev = 1'b0;
  logic ferr_prev = 1'b0;

  serial_move_rx #(
    .CLK_HZ(768_000), .BAUD_RATE(9600), .SAMP_PER_BIT(16), .PKT_LEN(8),
    .CLK_PER_SAMP(CPS), .WAITING_COUNT(WAIT)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rx_in(rx_in),
    .data_out(data_out), .ready(ready), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc++;

  always @(negedge clk_in) begin
    if (ready) begin
      ready_cnt++;
      ready_cyc = cyc;
    end
    if (frame_err) ferr_cnt++;
    if (ready && frame_err) overlap = 1'b1;
    if ((ready && ready_prev) || (frame_err && ferr_prev)) wide = 1'b1;
    ready_prev = ready;
    ferr_prev  = frame_err;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input bit spike,
                            input int nbits, output int start_cyc);
    logic [9:0] fr;
    fr = {stop_bit, d, 1'b0};
    start_cyc = 0;
    for (int b = 0; b < nbits; b++) begin
      for (int j = 0; j < BIT; j++) begin
        @(negedge clk_in);
        if (b == 0 && j == 0) start_cyc = cyc;
        rx_in = fr[b];
        if (spike && b == 4 && j >= 8*CPS-2 && j <= 8*CPS+2) rx_in = 1'b1;
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk_in);
      n++;
    end
    vec_cnt++;
    if (busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL %s: busy=%b required 0 (timeout)", name, busy);
    end
  endtask

  task automatic test_reset();
    repeat (4) @(negedge clk_in);
    vec_cnt++;
    if ({data_out, ready, frame_err, busy} !== 11'h0) begin
      err_cnt++;
      $display("FAIL reset_state: data=%h rdy=%b ferr=%b busy=%b required 0", data_out, ready, frame_err, busy);
    end
    rst_in = 1'b1;
    repeat (20) @(negedge clk_in);
    vec_cnt++;
    if (busy !== 1'b0 || ready_cnt != 0) begin
      err_cnt++;
      $display("FAIL reset_idle: busy=%b readies=%0d required 0/0", busy, ready_cnt);
    end
  endtask

  task automatic test_nominal();
    int r0, f0, st;
    r0 = ready_cnt; f0 = ferr_cnt;
    send_frame(8'hA5, 1'b1, 1'b0, 10, st);
    vec_cnt++;
    if (ready_cnt - r0 != 1) begin
      err_cnt++;
      $display("FAIL nominal_count: ready pulses=%0d required 1", ready_cnt - r0);
    end
    vec_cnt++;
    if (ready_cyc - st < LAT - 2 || ready_cyc - st > LAT + 2) begin
      err_cnt++;
      $display("FAIL nominal_latency: got %0d clocks required %0d+-2", ready_cyc - st, LAT);
    end
    vec_cnt++;
    if (data_out !== 8'hA5 || ferr_cnt != f0) begin
      err_cnt++;
      $display("FAIL nominal_data: data=%h ferr=%0d required a5/0", data_out, ferr_cnt - f0);
    end
    vec_cnt++;
    if (busy !== 1'b1) begin
      err_cnt++;
      $display("FAIL nominal_holdoff_busy: busy=%b required 1", busy);
    end
    wait_idle("nominal_idle");
    vec_cnt++;
    if (data_out !== 8'hA5) begin
      err_cnt++;
      $display("FAIL nominal_hold: data=%h required a5", data_out);
    end
  endtask

  task automatic test_reset_mid_frame();
    int r0, f0, st;
    r0 = ready_cnt; f0 = ferr_cnt;
    send_frame(8'hA5, 1'b1, 1'b0, 5, st);
    repeat (BIT/2) begin
      @(negedge clk_in);
      rx_in = 1'b0;
    end
    vec_cnt++;
    if (busy !== 1'b1) begin
      err_cnt++;
      $display("FAIL midrst_busy_before: busy=%b required 1", busy);
    end
    @(negedge clk_in);
    rst_in = 1'b0;
    rx_in  = 1'b1;
    repeat (3) @(negedge clk_in);
    vec_cnt++;
    if ({data_out, ready, frame_err, busy} !== 11'h0) begin
      err_cnt++;
      $display("FAIL midrst_in_reset: data=%h rdy=%b ferr=%b busy=%b required 0", data_out, ready, frame_err, busy);
    end
    rst_in = 1'b1;
    repeat (12 * BIT) @(negedge clk_in);
    vec_cnt++;
    if (ready_cnt != r0 || ferr_cnt != f0 || busy !== 1'b0 || data_out !== 8'h00) begin
      err_cnt++;
      $display("FAIL midrst_after: readies=%0d ferrs=%0d busy=%b data=%h required 0/0/0/00",
               ready_cnt - r0, ferr_cnt - f0, busy, data_out);
    end
  endtask

  task automatic test_false_start();
    int r0, f0, n;
    r0 = ready_cnt; f0 = ferr_cnt;
    n = 0;
    for (int j = 0; j < 3*CPS; j++) begin
      @(negedge clk_in);
      rx_in = 1'b0;
    end
    vec_cnt++;
    if (busy !== 1'b1) begin
      err_cnt++;
      $display("FAIL false_start_armed: busy=%b required 1", busy);
    end
    @(negedge clk_in);
    rx_in = 1'b1;
    while (busy && n < 16*CPS) begin
      @(negedge clk_in);
      n++;
    end
    vec_cnt++;
    if (busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL false_start_drop: busy=%b required 0 within %0d clocks", busy, 16*CPS);
    end
    repeat (12 * BIT) @(negedge clk_in);
    vec_cnt++;
    if (ready_cnt != r0 || ferr_cnt != f0 || data_out !== 8'h00) begin
      err_cnt++;
      $display("FAIL false_start_quiet: readies=%0d ferrs=%0d data=%h required 0/0/00",
               ready_cnt - r0, ferr_cnt - f0, data_out);
    end
  endtask

  task automatic test_noise_spike();
    int r0, st;
    r0 = ready_cnt;
    send_frame(8'h00, 1'b1, 1'b1, 10, st);
    vec_cnt++;
    if (ready_cnt - r0 != 1 || data_out !== 8'h00) begin
      err_cnt++;
      $display("FAIL noise_spike: readies=%0d data=%h required 1/00", ready_cnt - r0, data_out);
    end
    wait_idle("noise_idle");
  endtask

  task automatic test_frame_err();
    int r0, f0, st;
    send_frame(8'hA5, 1'b1, 1'b0, 10, st);
    wait_idle("ferr_pre_idle");
    vec_cnt++;
    if (data_out !== 8'hA5) begin
      err_cnt++;
      $display("FAIL ferr_pre_data: data=%h required a5", data_out);
    end
    r0 = ready_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, 10, st);
    vec_cnt++;
    if (ferr_cnt - f0 != 1 || ready_cnt != r0 || data_out !== 8'hA5) begin
      err_cnt++;
      $display("FAIL frame_err: ferrs=%0d readies=%0d data=%h required 1/0/a5",
               ferr_cnt - f0, ready_cnt - r0, data_out);
    end
    repeat (WAIT + 5*BIT) @(negedge clk_in);
    vec_cnt++;
    if (busy !== 1'b0 || ferr_cnt - f0 != 1 || ready_cnt != r0) begin
      err_cnt++;
      $display("FAIL ferr_break_hold: busy=%b ferrs=%0d readies=%0d required 0/1/0",
               busy, ferr_cnt - f0, ready_cnt - r0);
    end
    rx_in = 1'b1;
    repeat (BIT) @(negedge clk_in);
    vec_cnt++;
    if (busy !== 1'b0 || data_out !== 8'hA5) begin
      err_cnt++;
      $display("FAIL ferr_release: busy=%b data=%h required 0/a5", busy, data_out);
    end
  endtask

  task automatic test_holdoff();
    int r0, r1, f0, st, rc;
    r0 = ready_cnt; f0 = ferr_cnt;
    send_frame(8'h11, 1'b1, 1'b0, 10, st);
    rc = ready_cyc;
    r1 = ready_cnt;
    vec_cnt++;
    if (r1 - r0 != 1 || data_out !== 8'h11) begin
      err_cnt++;
      $display("FAIL holdoff_first: readies=%0d data=%h required 1/11", r1 - r0, data_out);
    end
    while (cyc < rc + 355) @(negedge clk_in);
    for (int j = 0; j < BIT; j++) begin
      @(negedge clk_in);
      rx_in = 1'b0;
    end
    @(negedge clk_in);
    rx_in = 1'b1;
    while (cyc < rc + 827) @(negedge clk_in);
    vec_cnt++;
    if (ready_cnt != r1 || busy !== 1'b0 || data_out !== 8'h11) begin
      err_cnt++;
      $display("FAIL holdoff_ignored: readies=%0d busy=%b data=%h required 0/0/11",
               ready_cnt - r1, busy, data_out);
    end
    send_frame(8'h5A, 1'b1, 1'b0, 10, st);
    vec_cnt++;
    if (ready_cnt - r1 != 1 || data_out !== 8'h5A || ferr_cnt != f0) begin
      err_cnt++;
      $display("FAIL holdoff_next: readies=%0d data=%h ferrs=%0d required 1/5a/0",
               ready_cnt - r1, data_out, ferr_cnt - f0);
    end
    wait_idle("holdoff_idle");
  endtask

  task automatic test_pulse_shape();
    vec_cnt++;
    if (overlap || wide) begin
      err_cnt++;
      $display("FAIL pulse_shape: overlap=%b wide=%b required 0/0", overlap, wide);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_reset_mid_frame();
    test_false_start();
    test_noise_spike();
    test_frame_err();
    test_holdoff();
    test_pulse_shape();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
